// File: rtl/div_sequencer.sv
// Sequential 32-bit DIV/DIVU unit for the EX stage: restoring, one bit per cycle.
// Define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        stall_request,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DZ   = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [32:0] r_prem;
  logic [31:0] r_qsh;
  logic [31:0] r_dvsr;
  logic [31:0] r_dvnd;
  logic        r_q_neg;
  logic        r_r_neg;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic        r_dz;

  logic [1:0]  w_state_nx;
  logic        w_to_done;
  logic        w_accept;
  logic        w_early;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_ge;
  logic [32:0] w_prem_nx;
  logic [31:0] w_q_nx;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;
  logic [31:0] w_res_q;
  logic [31:0] w_res_r;
  logic        w_res_dz;

  assign w_accept = (r_state == S_IDLE)
                  & start & ~annul;

  // Two's-complement negate of 0x80000000 is its own unsigned magnitude.
  assign w_abs_a = (signed_op & dividend[31])
                 ? -dividend : dividend;
  assign w_abs_b = (signed_op & divisor[31])
                 ? -divisor : divisor;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (divisor != 32'd0)
                 & (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_shift   = {r_prem, r_qsh[31]};
  assign w_diff    = w_shift - {2'b00, r_dvsr};
  assign w_ge      = ~w_diff[33];
  assign w_prem_nx = w_ge ? w_diff[32:0]
                          : w_shift[32:0];
  assign w_q_nx    = {r_qsh[30:0], w_ge};

  assign w_q_fin = r_q_neg ? -w_q_nx : w_q_nx;
  assign w_r_fin = r_r_neg ? -w_prem_nx[31:0]
                           : w_prem_nx[31:0];

  always_comb begin
    w_state_nx = r_state;
    w_to_done  = 1'b0;
    w_res_q    = w_q_fin;
    w_res_r    = w_r_fin;
    w_res_dz   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor == 32'd0) begin
            w_state_nx = S_DZ;
          end else if (w_early) begin
            w_state_nx = S_DONE;
            w_to_done  = 1'b1;
            w_res_q    = 32'd0;
            w_res_r    = dividend;
          end else begin
            w_state_nx = S_RUN;
          end
        end
      end
      S_DZ: begin
        w_state_nx = S_DONE;
        w_to_done  = 1'b1;
        w_res_q    = 32'hFFFF_FFFF;
        w_res_r    = r_dvnd;
        w_res_dz   = 1'b1;
      end
      S_RUN: begin
        if (r_cnt == 6'd31) begin
          w_state_nx = S_DONE;
          w_to_done  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    // A flush wins over every transition and keeps the old result.
    if (annul) begin
      w_state_nx = S_IDLE;
      w_to_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_prem  <= 33'd0;
      r_qsh   <= 32'd0;
      r_dvsr  <= 32'd0;
      r_dvnd  <= 32'd0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_dvnd  <= dividend;
        r_qsh   <= w_abs_a;
        r_dvsr  <= w_abs_b;
        r_prem  <= 33'd0;
        r_cnt   <= 6'd0;
        r_q_neg <= signed_op
                 & (dividend[31] ^ divisor[31]);
        r_r_neg <= signed_op & dividend[31];
      end else if ((r_state == S_RUN) && !annul) begin
        r_prem <= w_prem_nx;
        r_qsh  <= w_q_nx;
        r_cnt  <= r_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quo <= 32'd0;
      r_rem <= 32'd0;
      r_dz  <= 1'b0;
    end else if (w_to_done) begin
      r_quo <= w_res_q;
      r_rem <= w_res_r;
      r_dz  <= w_res_dz;
    end
  end

  assign stall_request = w_accept
                       | (r_state == S_RUN)
                       | (r_state == S_DZ);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: random and directed DIV/DIVU traffic.
// Reference results come from 64-bit integer arithmetic.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        annul = 1'b0;
  logic        stall_request;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_op    (signed_op),
    .dividend     (dividend),
    .divisor      (divisor),
    .annul        (annul),
    .stall_request(stall_request),
    .done         (done),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          sc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int n_cmp = 0;
  int n_err = 0;

  function automatic exp_t model(bit s, logic [31:0] a,
                                 logic [31:0] b, int sc);
    exp_t e;
    longint x, y, ax, ay;
    x = a;
    y = b;
    if (s && a[31]) x = x - 64'sd4294967296;
    if (s && b[31]) y = y - 64'sd4294967296;
    e.sc  = sc;
    e.dz  = 1'b0;
    e.lat = 33;
    if (b == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 2;
    end else begin
      e.q = 32'(x / y);
      e.r = 32'(x % y);
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
`ifdef DIV_EARLY_OUT_EN
      if (ax < ay) e.lat = 1;
`else
      if (ax < ay) e.lat = 33;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done q=%h r=%h cyc=%0d",
                 quotient, remainder, cyc);
      end else begin
        m_e = sb.pop_front();
        n_cmp++;
        if (quotient !== m_e.q || remainder !== m_e.r ||
            div_by_zero !== m_e.dz) begin
          n_err++;
          $display("FAIL result q=%h want %h r=%h want %h dz=%b want %b",
                   quotient, m_e.q, remainder, m_e.r,
                   div_by_zero, m_e.dz);
        end
        n_cmp++;
        if (cyc - m_e.sc != m_e.lat) begin
          n_err++;
          $display("FAIL latency got %0d want %0d",
                   cyc - m_e.sc, m_e.lat);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h cyc=%0d",
               nm, act, want, cyc);
    end
  endtask

  task automatic issue(bit s, logic [31:0] a,
                       logic [31:0] b, bit push);
    @(negedge clk);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    if (push) sb.push_back(model(s, a, b, cyc));
  endtask

  task automatic wait_done(bit noise);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0;
        return;
      end
      if (noise) begin
        start    = 1'($urandom_range(1, 0));
        dividend = $urandom;
        divisor  = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_cmp++;
    n_err++;
    $display("FAIL done_timeout cyc=%0d", cyc);
    sb.delete();
  endtask

  task automatic run_op(bit s, logic [31:0] a,
                        logic [31:0] b, bit noise);
    issue(s, a, b, 1'b1);
    wait_done(noise);
  endtask

  task automatic quiet(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit s;
    int sel;
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall_request), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    #14 rst = 1'b1;

    issue(1'b0, 32'd100, 32'd7, 1'b1);
    #1 chk("stall_c0", 32'(stall_request), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("stall_run", 32'(stall_request), 32'd1);
    end
    @(negedge clk);
    chk("done_c33", 32'(done), 32'd1);
    chk("stall_done", 32'(stall_request), 32'd0);

    run_op(1'b1, -32'sd7, 32'd2, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, -32'sd5, 32'd0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(1'b1, -32'sd9, 32'd3, 1'b0);
    run_op(1'b0, 32'd3, 32'd9, 1'b0);

    issue(1'b0, 32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_stall", 32'(stall_request), 32'd0);
    chk("annul_done", 32'(done), 32'd0);
    chk("annul_q", quotient, 32'd0);
    chk("annul_r", remainder, 32'd3);
    quiet(40);

    issue(1'b0, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    quiet(4);
    #2 rst = 1'b0;
    #1;
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_stall", 32'(stall_request), 32'd0);
    chk("mrst_q", quotient, 32'd0);
    chk("mrst_r", remainder, 32'd0);
    chk("mrst_dz", 32'(div_by_zero), 32'd0);
    quiet(2);
    rst = 1'b1;
    quiet(40);

    issue(1'b0, 32'd1000, 32'd3, 1'b1);
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    chk("b2b_first_done", 32'(done), 32'd1);
    signed_op = 1'b1;
    dividend  = -32'sd1000;
    divisor   = 32'd7;
    sb.push_back(model(1'b1, -32'sd1000, 32'd7, cyc + 1));
    @(negedge clk);
    chk("b2b_stall", 32'(stall_request), 32'd1);
    chk("b2b_hold_q", quotient, 32'd333);
    chk("b2b_hold_r", remainder, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_run_q", quotient, 32'd333);
    wait_done(1'b0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(5, 0);
      s = 1'($urandom_range(1, 0));
      a = $urandom;
      b = $urandom;
      unique case (sel)
        0: b = 32'd0;
        1: begin
          b = $urandom_range(1000, 20);
          a = $urandom_range(19, 0);
        end
        2: b = $urandom_range(1, 0) ? 32'd1 : 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: b = b >> $urandom_range(31, 0);
      endcase
      run_op(s, a, b, 1'b1);
    end

    quiet(3);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL leftover got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
